// File: rtl/scsu_ahb_pkg.sv
// Shared AHB-Lite encodings and request bundle for the SCSU master bridge.
// Lane steering helpers shared by the write and read data paths.
package scsu_ahb_pkg;

    localparam int REQ_AW = 16;
    localparam int REQ_DW = 16;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HSIZE_BYTE    = 2'b00;
    localparam logic [1:0] HSIZE_HALF    = 2'b01;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [REQ_AW-1:0] addr;
        logic [REQ_DW-1:0] wdata;
    } req_t;

    function automatic logic [REQ_DW-1:0] lane_wdata(
        input logic [1:0]        size,
        input logic [REQ_DW-1:0] wdata
    );
        if (size == HSIZE_BYTE)
            return {wdata[7:0], wdata[7:0]};
        return wdata;
    endfunction

    function automatic logic [REQ_DW-1:0] lane_rdata(
        input logic [1:0]        size,
        input logic              a0,
        input logic [REQ_DW-1:0] rdata
    );
        if (size == HSIZE_BYTE)
            return {8'h00, a0 ? rdata[15:8] : rdata[7:0]};
        return rdata;
    endfunction

endpackage

// File: rtl/scsu_ahb_master_req_fifo.sv
// Two-entry request FIFO between the core handshake and the AHB address slot.
// Flush empties it in one cycle; storage itself is not reset.
module scsu_ahb_req_fifo
    import scsu_ahb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  req_t din,
    output req_t dout,
    output logic full,
    output logic empty
);

    req_t       mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
    assign dout  = mem[rd_ptr];

    // Storage write; pointers qualify which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking with single-bit wrap.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/scsu_ahb_master.sv
// Pipelined AHB-Lite master: FIFO -> address slot -> data slot -> response.
// Optional data-phase watchdog enabled by SCSU_AHB_MASTER_TIMEOUT_EN.
module scsu_ahb_master
    import scsu_ahb_pkg::*;
#(
    parameter int ADDR_W      = REQ_AW,
    parameter int DATA_W      = REQ_DW,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_timeout,
    output logic [1:0]        scsu_m_ahb_mhtrans,
    output logic [1:0]        scsu_m_ahb_mhsize,
    output logic              scsu_m_ahb_mhwrite,
    output logic [ADDR_W-1:0] scsu_m_ahb_mhaddr,
    output logic [DATA_W-1:0] scsu_m_ahb_mhwdata,
    input  logic [DATA_W-1:0] ahb_scsu_m_shrdata,
    input  logic              ahb_scsu_m_shready,
    input  logic [1:0]        ahb_scsu_m_shresp
);

    req_t        fifo_din;
    req_t        head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        tmo_fire;

    logic              a_valid;
    logic              a_err;
    logic [DATA_W-1:0] a_wdata;
    logic              d_valid;
    logic              d_wr;
    logic [1:0]        d_size;
    logic              d_a0;
    logic              d_err;

    assign fifo_din  = '{wr: req_wr, size: req_size,
                         addr: req_addr, wdata: req_wdata};
    assign req_ready = !rst && !full;
    assign push      = req_valid && req_ready;
    assign pop       = ahb_scsu_m_shready && !empty && !tmo_fire;

    scsu_ahb_req_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (tmo_fire),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef SCSU_AHB_MASTER_TIMEOUT_EN
    logic [7:0] stall_cnt;
    logic       tmo_flag;

    assign tmo_fire = d_valid && !ahb_scsu_m_shready
                   && (stall_cnt == 8'(TIMEOUT_CYC - 1));
    assign bus_timeout = tmo_flag;

    // Count consecutive stalled data-phase cycles; sticky flag on expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 8'd0;
            tmo_flag  <= 1'b0;
        end else if (tmo_fire) begin
            stall_cnt <= 8'd0;
            tmo_flag  <= 1'b1;
        end else if (d_valid && !ahb_scsu_m_shready) begin
            stall_cnt <= stall_cnt + 8'd1;
        end else begin
            stall_cnt <= 8'd0;
        end
    end
`else
    assign tmo_fire    = 1'b0;
    assign bus_timeout = 1'b0;
`endif

    // Advance address/data slots on HREADY and emit in-order responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid            <= 1'b0;
            a_err              <= 1'b0;
            a_wdata            <= '0;
            d_valid            <= 1'b0;
            d_wr               <= 1'b0;
            d_size             <= HSIZE_BYTE;
            d_a0               <= 1'b0;
            d_err              <= 1'b0;
            rsp_valid          <= 1'b0;
            rsp_rdata          <= '0;
            rsp_err            <= 1'b0;
            scsu_m_ahb_mhtrans <= HTRANS_IDLE;
            scsu_m_ahb_mhsize  <= HSIZE_BYTE;
            scsu_m_ahb_mhwrite <= 1'b0;
            scsu_m_ahb_mhaddr  <= '0;
            scsu_m_ahb_mhwdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (tmo_fire) begin
                rsp_valid          <= 1'b1;
                rsp_err            <= 1'b1;
                rsp_rdata          <= '0;
                d_valid            <= 1'b0;
                a_valid            <= 1'b0;
                a_err              <= 1'b0;
                scsu_m_ahb_mhtrans <= HTRANS_IDLE;
            end else if (ahb_scsu_m_shready) begin
                if (d_valid) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= (ahb_scsu_m_shresp != HRESP_OKAY) || d_err;
                    rsp_rdata <= (d_wr || d_err) ? '0
                               : lane_rdata(d_size, d_a0, ahb_scsu_m_shrdata);
                end
                d_valid            <= a_valid;
                d_wr               <= scsu_m_ahb_mhwrite;
                d_size             <= scsu_m_ahb_mhsize;
                d_a0               <= scsu_m_ahb_mhaddr[0];
                d_err              <= a_err;
                scsu_m_ahb_mhwdata <= a_wdata;
                if (!empty) begin
                    a_valid            <= 1'b1;
                    a_err              <= head.size[1];
                    a_wdata            <= lane_wdata(head.size, head.wdata);
                    scsu_m_ahb_mhtrans <= head.size[1] ? HTRANS_IDLE
                                                       : HTRANS_NONSEQ;
                    scsu_m_ahb_mhsize  <= head.size;
                    scsu_m_ahb_mhwrite <= head.wr;
                    scsu_m_ahb_mhaddr  <= head.addr;
                end else begin
                    a_valid            <= 1'b0;
                    a_err              <= 1'b0;
                    scsu_m_ahb_mhtrans <= HTRANS_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_scsu_ahb_master.sv
// Directed bench for scsu_ahb_master with a zero-wait byte-lane RAM slave.
// Define SCSU_AHB_MASTER_TIMEOUT_EN to also exercise the watchdog.
module tb_scsu_ahb_master;

`ifdef SCSU_AHB_MASTER_TIMEOUT_EN
    localparam int TCYC = 4;
`else
    localparam int TCYC = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wr = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_timeout;
    logic [1:0]  mhtrans;
    logic [1:0]  mhsize;
    logic        mhwrite;
    logic [15:0] mhaddr;
    logic [15:0] mhwdata;
    logic [15:0] shrdata;
    logic        shready = 1'b1;
    logic [1:0]  shresp = 2'b00;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nonseq_cnt = 0;

    logic [15:0] rq_data[$];
    logic        rq_err[$];
    int          rq_cyc[$];

    always #5 clk = ~clk;

    scsu_ahb_master #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(TCYC)) dut (
        .clk                (clk),
        .rst                (rst),
        .req_valid          (req_valid),
        .req_ready          (req_ready),
        .req_wr             (req_wr),
        .req_size           (req_size),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .rsp_valid          (rsp_valid),
        .rsp_rdata          (rsp_rdata),
        .rsp_err            (rsp_err),
        .bus_timeout        (bus_timeout),
        .scsu_m_ahb_mhtrans (mhtrans),
        .scsu_m_ahb_mhsize  (mhsize),
        .scsu_m_ahb_mhwrite (mhwrite),
        .scsu_m_ahb_mhaddr  (mhaddr),
        .scsu_m_ahb_mhwdata (mhwdata),
        .ahb_scsu_m_shrdata (shrdata),
        .ahb_scsu_m_shready (shready),
        .ahb_scsu_m_shresp  (shresp)
    );

    // Slave: byte-addressed RAM with a registered data phase.
    logic [7:0] mem [256];
    logic       sp_valid = 1'b0;
    logic       sp_wr = 1'b0;
    logic [1:0] sp_size = 2'b00;
    logic [7:0] sp_addr = '0;
    logic [7:0] sp_even;

    assign sp_even = {sp_addr[7:1], 1'b0};
    assign shrdata = {mem[sp_even + 8'd1], mem[sp_even]};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    end

    // Slave data phase: perform write, then accept the next address phase.
    always @(posedge clk) begin
        if (shready) begin
            if (sp_valid && sp_wr) begin
                if (sp_size == 2'b01) begin
                    mem[sp_even]        <= mhwdata[7:0];
                    mem[sp_even + 8'd1] <= mhwdata[15:8];
                end else if (sp_addr[0]) begin
                    mem[sp_addr] <= mhwdata[15:8];
                end else begin
                    mem[sp_addr] <= mhwdata[7:0];
                end
            end
            sp_valid <= !rst && (mhtrans == 2'b10);
            sp_wr    <= mhwrite;
            sp_size  <= mhsize;
            sp_addr  <= mhaddr[7:0];
        end
    end

    // Response and bus-activity monitor sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rsp_valid) begin
            rq_data.push_back(rsp_rdata);
            rq_err.push_back(rsp_err);
            rq_cyc.push_back(cyc);
        end
        if (shready && mhtrans == 2'b10)
            nonseq_cnt <= nonseq_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        rq_data.delete();
        rq_err.delete();
        rq_cyc.delete();
    endtask

    task automatic send(input logic wr, input logic [1:0] size,
                        input logic [15:0] addr, input logic [15:0] wdata);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (n == 20) begin
            bad++;
            $display("FAIL send_ready: req_ready=%0b required=1", req_ready);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k;
        k = 0;
        while (rq_err.size() < n && k < 40) begin
            tick();
            k++;
        end
        tick();
        total++;
        if (rq_err.size() != n) begin
            bad++;
            $display("FAIL rsp_count: got=%0d required=%0d", rq_err.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: got=%0b required=0", req_ready);
        end
        rst = 1'b0;
        tick();
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_ready: got=%0b required=1", req_ready);
        end
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata, bus_timeout, mhtrans, mhsize,
             mhwrite, mhaddr, mhwdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: trans=%h addr=%h wdata=%h rsp=%b/%h required all 0",
                     mhtrans, mhaddr, mhwdata, rsp_valid, rsp_rdata);
        end
    endtask

    task automatic test_single_write();
        clear_q();
        send(1'b1, 2'b01, 16'h0010, 16'hBEEF);
        total++;
        if (mhtrans !== 2'b00) begin
            bad++;
            $display("FAIL wr_no_bypass: trans=%h required=00", mhtrans);
        end
        tick();
        total++;
        if ({mhtrans, mhwrite, mhsize, mhaddr} !== {2'b10, 1'b1, 2'b01, 16'h0010}) begin
            bad++;
            $display("FAIL wr_addr_phase: trans=%h wr=%b size=%h addr=%h required 2/1/1/0010",
                     mhtrans, mhwrite, mhsize, mhaddr);
        end
        tick();
        total++;
        if (mhwdata !== 16'hBEEF || mhtrans !== 2'b00) begin
            bad++;
            $display("FAIL wr_data_phase: wdata=%h trans=%h required BEEF/00", mhwdata, mhtrans);
        end
        tick();
        total++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL wr_rsp: v=%b err=%b rdata=%h required 1/0/0000",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
        total++;
        if (rsp_valid !== 1'b0 || rq_err.size() != 1) begin
            bad++;
            $display("FAIL wr_rsp_pulse: v=%b count=%0d required 0/1", rsp_valid, rq_err.size());
        end
    endtask

    task automatic test_byte_lanes();
        clear_q();
        send(1'b1, 2'b00, 16'h0021, 16'h0034);
        tick();
        tick();
        total++;
        if (mhwdata !== 16'h3434) begin
            bad++;
            $display("FAIL byte_wdata: got=%h required=3434", mhwdata);
        end
        send(1'b1, 2'b00, 16'h0020, 16'h00AB);
        send(1'b0, 2'b01, 16'h0020, 16'h0000);
        send(1'b0, 2'b00, 16'h0021, 16'h0000);
        send(1'b0, 2'b00, 16'h0020, 16'h0000);
        wait_rsp(5);
        if (rq_data.size() == 5) begin
            total++;
            if (rq_data[2] !== 16'h34AB) begin
                bad++;
                $display("FAIL half_read_20: got=%h required=34AB", rq_data[2]);
            end
            total++;
            if (rq_data[3] !== 16'h0034) begin
                bad++;
                $display("FAIL byte_read_21: got=%h required=0034", rq_data[3]);
            end
            total++;
            if (rq_data[4] !== 16'h00AB) begin
                bad++;
                $display("FAIL byte_read_20: got=%h required=00AB", rq_data[4]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        send(1'b1, 2'b01, 16'h0040, 16'h1234);
        send(1'b0, 2'b01, 16'h0040, 16'h0000);
        send(1'b0, 2'b01, 16'h0010, 16'h0000);
        wait_rsp(3);
        if (rq_data.size() == 3) begin
            total++;
            if (rq_data[1] !== 16'h1234 || rq_data[2] !== 16'hBEEF) begin
                bad++;
                $display("FAIL b2b_data: got=%h,%h required=1234,BEEF", rq_data[1], rq_data[2]);
            end
            total++;
            if (rq_cyc[1] - rq_cyc[0] != 1 || rq_cyc[2] - rq_cyc[1] != 1) begin
                bad++;
                $display("FAIL b2b_rate: gaps=%0d,%0d required=1,1",
                         rq_cyc[1] - rq_cyc[0], rq_cyc[2] - rq_cyc[1]);
            end
        end
    endtask

    task automatic test_stall();
        clear_q();
        send(1'b0, 2'b01, 16'h0010, 16'h0000);
        tick();
        shready = 1'b0;
        send(1'b0, 2'b01, 16'h0040, 16'h0000);
        send(1'b0, 2'b00, 16'h0021, 16'h0000);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL stall_full: req_ready=%b required=0", req_ready);
        end
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({mhtrans, mhwrite, mhsize, mhaddr} !== {2'b10, 1'b0, 2'b01, 16'h0010}) begin
                bad++;
                $display("FAIL stall_hold: trans=%h wr=%b addr=%h required 2/0/0010",
                         mhtrans, mhwrite, mhaddr);
            end
            if (i == 0) tick();
        end
        shready = 1'b1;
        wait_rsp(3);
        if (rq_data.size() == 3) begin
            total++;
            if ({rq_data[0], rq_data[1], rq_data[2]} !== {16'hBEEF, 16'h1234, 16'h0034}) begin
                bad++;
                $display("FAIL stall_order: got=%h,%h,%h required=BEEF,1234,0034",
                         rq_data[0], rq_data[1], rq_data[2]);
            end
        end
    endtask

    task automatic test_illegal_size();
        int ns0;
        clear_q();
        ns0 = nonseq_cnt;
        send(1'b0, 2'b01, 16'h0010, 16'h0000);
        send(1'b0, 2'b10, 16'h0040, 16'h0000);
        send(1'b0, 2'b01, 16'h0040, 16'h0000);
        wait_rsp(3);
        total++;
        if (nonseq_cnt - ns0 != 2) begin
            bad++;
            $display("FAIL illegal_nonseq: got=%0d required=2", nonseq_cnt - ns0);
        end
        if (rq_err.size() == 3) begin
            total++;
            if ({rq_err[0], rq_err[1], rq_err[2]} !== 3'b010) begin
                bad++;
                $display("FAIL illegal_err: got=%b%b%b required=010",
                         rq_err[0], rq_err[1], rq_err[2]);
            end
            total++;
            if ({rq_data[0], rq_data[1], rq_data[2]} !== {16'hBEEF, 16'h0000, 16'h1234}) begin
                bad++;
                $display("FAIL illegal_data: got=%h,%h,%h required=BEEF,0000,1234",
                         rq_data[0], rq_data[1], rq_data[2]);
            end
        end
    endtask

    task automatic test_bus_error();
        clear_q();
        shresp = 2'b01;
        send(1'b0, 2'b01, 16'h0010, 16'h0000);
        wait_rsp(1);
        shresp = 2'b00;
        if (rq_err.size() == 1) begin
            total++;
            if (rq_err[0] !== 1'b1) begin
                bad++;
                $display("FAIL bus_err: got=%b required=1", rq_err[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_q();
        send(1'b1, 2'b01, 16'h0050, 16'h5555);
        tick();
        rst = 1'b1;
        tick();
        total++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata, mhtrans, mhsize,
             mhwrite, mhaddr, mhwdata} !== '0) begin
            bad++;
            $display("FAIL rst_mid_out: rdy=%b trans=%h addr=%h wdata=%h required all 0",
                     req_ready, mhtrans, mhaddr, mhwdata);
        end
        rst = 1'b0;
        repeat (4) tick();
        total++;
        if (rq_err.size() != 0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_drop: rsp_count=%0d rdy=%b required 0/1",
                     rq_err.size(), req_ready);
        end
    endtask

    task automatic test_timeout();
`ifdef SCSU_AHB_MASTER_TIMEOUT_EN
        clear_q();
        send(1'b0, 2'b01, 16'h0010, 16'h0000);
        tick();
        tick();
        shready = 1'b0;
        repeat (3) tick();
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL tmo_early: rsp_valid=%b required=0", rsp_valid);
        end
        tick();
        total++;
        if ({rsp_valid, rsp_err, bus_timeout, mhtrans} !== {3'b111, 2'b00}) begin
            bad++;
            $display("FAIL tmo_fire: v=%b err=%b tmo=%b trans=%h required 1/1/1/00",
                     rsp_valid, rsp_err, bus_timeout, mhtrans);
        end
        shready = 1'b1;
        repeat (2) tick();
        total++;
        if (bus_timeout !== 1'b1) begin
            bad++;
            $display("FAIL tmo_sticky: got=%b required=1", bus_timeout);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (bus_timeout !== 1'b0) begin
            bad++;
            $display("FAIL tmo_clear: got=%b required=0", bus_timeout);
        end
`else
        shready = 1'b0;
        repeat (8) tick();
        total++;
        if (bus_timeout !== 1'b0) begin
            bad++;
            $display("FAIL tmo_tied: got=%b required=0", bus_timeout);
        end
        shready = 1'b1;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_byte_lanes();
        test_back_to_back();
        test_stall();
        test_illegal_size();
        test_bus_error();
        test_reset_mid();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
